// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART-to-RAM loader: receiver state encoding
// and the fixed byte, address and word widths.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;
  localparam int ADDR_W    = 6;
  localparam int WORD_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop input synchronizer, mid-bit sampling FSM and
// optional even-parity check (enabled by defining UART_RX_PARITY_EN).
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | half a bit in; low confirms a start bit, high is a glitch
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | (parity bit, if enabled, then) stop bit; after a bad frame,
//       | held here until the line is seen high again
module uart_rx_byte
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta, rx_sync, rx_prev;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 hold_q, hold_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 tick;
  logic                 stop_ok;
`ifdef UART_RX_PARITY_EN
  logic                 par_phase_q, par_phase_d;
  logic                 par_ok_q, par_ok_d;
`endif

  assign tick        = (cnt_q == '0);
  assign byte_valid  = valid_q;
  assign byte_data   = shift_q;
  assign frame_error = ferr_q;

  // Resynchronize the serial line; reset to idle-high so no false edge appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      hold_q    <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_phase_q <= 1'b0;
      par_ok_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_phase_q <= par_phase_d;
      par_ok_q    <= par_ok_d;
`endif
    end
  end

  // Next-state logic; sampling happens when the bit timer reaches zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    stop_ok   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_phase_d = par_phase_q;
    par_ok_d    = par_ok_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (tick) begin
          if (rx_sync) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = FULL_M1;
            bit_idx_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_M1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
`ifdef UART_RX_PARITY_EN
            par_phase_d = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (hold_q) begin
          if (rx_sync) begin
            state_d = IDLE;
            hold_d  = 1'b0;
          end
        end else if (tick) begin
`ifdef UART_RX_PARITY_EN
          if (par_phase_q) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            par_phase_d = 1'b0;
            par_ok_d    = (rx_sync == ^shift_q);
            cnt_d       = FULL_M1;
          end else begin
            stop_ok = rx_sync && par_ok_q;
`else
          begin
            stop_ok = rx_sync;
`endif
            if (stop_ok) begin
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d = 1'b1;
              if (rx_sync) state_d = IDLE;
              else         hold_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_to_ram.sv
// Loads a RAM from a UART byte stream: two bytes per word (big-endian),
// sequential addresses from 0, sticky load_done after WORD_COUNT words.
// Optional even parity on the serial frames via UART_RX_PARITY_EN.
module uart_rx_to_ram
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_COUNT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              enable_to_ram,
  output logic              write_enable_to_ram,
  output logic [ADDR_W-1:0] address_to_ram,
  output logic [WORD_W-1:0] data_to_ram,
  output logic              load_done,
  output logic              frame_error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 byte_ferr;

  logic                 hi_pending_q;
  logic [DATA_BITS-1:0] hi_byte_q;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_W-1:0]    data_q;
  logic                 done_q;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_error(byte_ferr)
  );

  assign enable_to_ram       = we_q;
  assign write_enable_to_ram = we_q;
  assign address_to_ram      = addr_q;
  assign data_to_ram         = data_q;
  assign load_done           = done_q;
  // Once loading is complete, rejected bytes are ignored silently too.
  assign frame_error         = byte_ferr & ~done_q;

  // Word assembly, write strobe, address advance and completion flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_pending_q <= 1'b0;
      hi_byte_q    <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q) begin
        // The final address is held rather than wrapped back to 0.
        if (addr_q == LAST_ADDR) done_q <= 1'b1;
        else                     addr_q <= addr_q + 1'b1;
      end
      if (!done_q) begin
        if (byte_ferr) begin
          hi_pending_q <= 1'b0;
        end else if (byte_valid) begin
          if (!hi_pending_q) begin
            hi_byte_q    <= byte_data;
            hi_pending_q <= 1'b1;
          end else begin
            data_q       <= {hi_byte_q, byte_data};
            we_q         <= 1'b1;
            hi_pending_q <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_to_ram.sv
// Self-checking bench for uart_rx_to_ram: directed and randomized serial
// frames scored against a word-level model of the loader.
module tb_uart_rx_to_ram;

  localparam int CPB = 16;
  localparam int WC  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx = 1'b1;
  logic        enable_to_ram, write_enable_to_ram, load_done, frame_error;
  logic [5:0]  address_to_ram;
  logic [15:0] data_to_ram;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit          m_pending;
  logic [7:0]  m_hi;
  int          m_addr;
  bit          m_done;
  int          exp_fe = 0;
  int          fe_seen = 0;
  logic [21:0] exp_q[$];

  uart_rx_to_ram #(.CLKS_PER_BIT(CPB), .WORD_COUNT(WC)) dut (
    .clk                (clk),
    .reset              (reset),
    .uart_rx            (uart_rx),
    .enable_to_ram      (enable_to_ram),
    .write_enable_to_ram(write_enable_to_ram),
    .address_to_ram     (address_to_ram),
    .data_to_ram        (data_to_ram),
    .load_done          (load_done),
    .frame_error        (frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loader behaviour at byte granularity.
  task automatic model_byte(input logic [7:0] d, input bit good);
    if (m_done) return;
    if (!good) begin
      exp_fe++;
      m_pending = 1'b0;
    end else if (!m_pending) begin
      m_hi      = d;
      m_pending = 1'b1;
    end else begin
      exp_q.push_back({m_addr[5:0], m_hi, d});
      m_pending = 1'b0;
      m_addr++;
      if (m_addr == WC) m_done = 1'b1;
    end
  endtask

  // Score every write strobe and count frame_error cycles.
  always @(negedge clk) begin
    logic [21:0] e;
    if (reset) begin
      if (frame_error) fe_seen++;
      if (write_enable_to_ram || enable_to_ram) begin
        check("en_eq_we", 32'(enable_to_ram), 32'(write_enable_to_ram));
        if (write_enable_to_ram) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(write_enable_to_ram), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(address_to_ram), 32'(e[21:16]));
            check("wr_data", 32'(data_to_ram), 32'(e[15:0]));
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_fe_count"}, 32'(fe_seen), 32'(exp_fe));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'(m_done));
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bad);
    bit good;
    good = stop_bit;
`ifdef UART_RX_PARITY_EN
    good = good && !par_bad;
`endif
    model_byte(d, good);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_bad);
`endif
    drive_bit(stop_bit);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    post_checks("frame");
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (len) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    post_checks("glitch");
  endtask

  // Assert reset at the current time; outputs must clear without a clock.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_we", 32'(write_enable_to_ram), 32'd0);
    check("rst_en", 32'(enable_to_ram), 32'd0);
    check("rst_addr", 32'(address_to_ram), 32'd0);
    check("rst_data", 32'(data_to_ram), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_fe", 32'(frame_error), 32'd0);
    check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    m_pending = 1'b0;
    m_addr    = 0;
    m_done    = 1'b0;
    uart_rx   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    bit         sb, pb;

    do_reset();

    // two bytes form one big-endian word at address 0
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);

    // a short low pulse is not a start bit; reception still works after it
    glitch(4);
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);

    // bad stop bit drops the byte; the next good byte is a high byte
    #2 do_reset();
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0);
    send_frame(8'h56, 1'b1, 1'b0);

    // reset in the middle of the second byte's data bits
    #2 do_reset();
    send_frame(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    #2 do_reset();
    send_frame(8'hBE, 1'b1, 1'b0);
    send_frame(8'hEF, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
    // wrong parity is a frame error with no write
    #2 do_reset();
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h21, 1'b1, 1'b0);
    send_frame(8'h43, 1'b1, 1'b0);
`endif

    // ten good random bytes: four words, then the rest ignored
    #2 do_reset();
    for (int k = 0; k < 10; k++) send_frame(8'($urandom), 1'b1, 1'b0);
    check("fill_addr_held", 32'(address_to_ram), 32'(WC - 1));

    // randomized mix of glitches, bad frames and good bytes
    for (int r = 0; r < 3; r++) begin
      #2 do_reset();
      for (int k = 0; k < 14; k++) begin
        if ($urandom_range(0, 3) == 0) glitch($urandom_range(2, CPB / 2 - 3));
        d  = 8'($urandom);
        sb = ($urandom_range(0, 4) != 0);
        pb = ($urandom_range(0, 5) == 0);
        send_frame(d, sb, pb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_to_ram.md
UART_RX_TO_RAM -- requirements
Module: uart_rx_to_ram

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200), legal range 16..65535.
REQ-002 SHALL have parameter WORD_COUNT, default 64, words loaded before completion, legal range 1..64.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1 framing.
REQ-006 SHALL have port enable_to_ram  output  1  RAM enable, high exactly when write_enable_to_ram is high.
REQ-007 SHALL have port write_enable_to_ram  output  1  one-cycle RAM write strobe.
REQ-008 SHALL have port address_to_ram  output  6  RAM word address.
REQ-009 SHALL have port data_to_ram  output  16  RAM write data.
REQ-010 SHALL have port load_done  output  1  sticky high once WORD_COUNT words are written.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse per rejected byte.

Function
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-013 Byte receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE->START on synchronized falling edge; START samples at CLKS_PER_BIT/2 (integer division); sample 1 = glitch -> IDLE with no error.
REQ-015 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals, LSB first; STOP samples one CLKS_PER_BIT later.
REQ-016 Stop sample 1 -> byte valid; stop sample 0 -> frame_error pulse, byte discarded, FSM returns to IDLE only after line is seen high.
REQ-017 Byte-valid strobe SHALL occur the cycle after the stop-bit sample.
REQ-018 Words SHALL assemble big-endian: first accepted byte -> data_to_ram[15:8], second -> [7:0].
REQ-019 write_enable_to_ram SHALL pulse one cycle, one cycle after the second byte-valid strobe, with address and data stable that cycle.
REQ-020 address_to_ram SHALL start at 0 and increment by 1 after each write; no wrap: after write to WORD_COUNT-1, load_done rises the next cycle.
REQ-021 A frame error SHALL discard any pending high byte so the next good byte is a high byte.
REQ-022 With load_done high, all further bytes SHALL be ignored: no writes, no frame_error pulses.
REQ-023 Counters SHALL be sized ceil(log2(CLKS_PER_BIT)) bits; bit index 3 bits; address 6 bits.

Reset
REQ-024 On reset low, all outputs SHALL go to 0 immediately (data_to_ram 16'h0000, address_to_ram 6'd0), FSM to IDLE, pending byte cleared, independent of clk.
REQ-025 Reset mid-frame SHALL abort the frame without a write; after release, reception restarts at the next falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: one even-parity bit between D7 and stop; a parity mismatch SHALL be handled as a frame error (REQ-016/021).
REQ-027 Macro undefined: 8N1 only, no parity logic synthesized.

Structure
REQ-028 Package uart_rx_pkg SHALL hold the FSM state enum, DATA_BITS=8, ADDR_W=6, WORD_W=16.
REQ-029 Sub-module uart_rx_byte SHALL contain synchronizer, bit FSM and parity; the top holds word assembly, address counter and load_done.

Verification
REQ-030 Bytes 8'hA5, 8'h3C at CLKS_PER_BIT=16 -> one write: addr 0, data 16'hA53C; enable_to_ram high that cycle only.
REQ-031 Low pulse of 4 cycles on uart_rx -> no byte, no frame_error, FSM back in IDLE.
REQ-032 Byte 8'h12 with stop bit 0, then 8'h34, 8'h56 -> one frame_error pulse, write data 16'h3456 at addr 0.
REQ-033 WORD_COUNT=4, send 10 bytes -> writes at addr 0..3, load_done high after 4th write, bytes 9-10 ignored.
REQ-034 reset low during DATA of the 2nd byte, then release and send 8'hBE, 8'hEF -> single write 16'hBEEF at addr 0.
REQ-035 With UART_RX_PARITY_EN defined, byte 8'h07 with parity bit 0 -> frame_error pulse, no write.
